// File: rtl/fetch_unit_pkg.sv
// Shared CPU package: fetch FSM encoding, reset vector and widths used by
// the fetch unit and the control unit.
package fetch_unit_pkg;

  localparam int unsigned IR_W           = 8;
  localparam int unsigned RST_PC_DEFAULT = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_FULL  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues byte fetches at pc and holds one fetched
// byte in a single-entry buffer until the control unit takes it.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned RST_PC = RST_PC_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IR_W-1:0]   mem_data,
  input  logic              mem_ready,
  input  logic              ir_take,
  input  logic              jmp_en,
  input  logic [ADDR_W-1:0] jmp_addr,
  input  logic              halt,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_req,
  output logic [IR_W-1:0]   ir_byte,
  output logic              ir_valid,
  output logic [ADDR_W-1:0] pc
);

  fetch_state_e state;

  assign mem_addr = pc;

  // A jump overrides any memory response or take in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      pc       <= ADDR_W'(RST_PC);
      ir_byte  <= '0;
      ir_valid <= 1'b0;
      mem_req  <= 1'b0;
    end else if (jmp_en) begin
      pc       <= jmp_addr;
      ir_valid <= 1'b0;
      if (halt) begin
        state   <= ST_IDLE;
        mem_req <= 1'b0;
      end else begin
        state   <= ST_FETCH;
        mem_req <= 1'b1;
      end
    end else begin
      case (state)
        ST_IDLE: begin
          if (!halt) begin
            state   <= ST_FETCH;
            mem_req <= 1'b1;
          end
        end
        ST_FETCH: begin
          // halt does not abort an outstanding request
          if (mem_ready) begin
            state    <= ST_FULL;
            ir_byte  <= mem_data;
            pc       <= pc + ADDR_W'(1);
            ir_valid <= 1'b1;
            mem_req  <= 1'b0;
          end
        end
        ST_FULL: begin
          if (ir_take) begin
            ir_valid <= 1'b0;
            if (halt) begin
              state   <= ST_IDLE;
              mem_req <= 1'b0;
            end else begin
              state   <= ST_FETCH;
              mem_req <= 1'b1;
            end
          end
        end
        default: begin
          state    <= ST_IDLE;
          ir_valid <= 1'b0;
          mem_req  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, async-reset sequence and a
// randomized run against a transaction-level reference model.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic [7:0]  mem_data;
  logic        mem_ready;
  logic        ir_take;
  logic        jmp_en;
  logic [15:0] jmp_addr;
  logic        halt;
  logic [15:0] mem_addr;
  logic        mem_req;
  logic [7:0]  ir_byte;
  logic        ir_valid;
  logic [15:0] pc;

  int checks = 0;
  int errors = 0;

  fetch_unit #(.ADDR_W(16), .RST_PC(0)) dut (
    .clk(clk), .rst(rst), .mem_data(mem_data), .mem_ready(mem_ready),
    .ir_take(ir_take), .jmp_en(jmp_en), .jmp_addr(jmp_addr), .halt(halt),
    .mem_addr(mem_addr), .mem_req(mem_req), .ir_byte(ir_byte),
    .ir_valid(ir_valid), .pc(pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ready;
    logic [7:0]  data;
    logic        take;
    logic        jmp;
    logic [15:0] addr;
    logic        hlt;
    logic        e_req;
    logic        e_valid;
    logic [7:0]  e_ir;
    logic [15:0] e_pc;
  } vec_t;

  localparam int NVEC = 22;
  vec_t vecs [NVEC];

  // Reference model: one-entry buffer plus an outstanding-request flag.
  logic        m_req, m_valid;
  logic [7:0]  m_ir;
  logic [15:0] m_pc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rd, input logic [7:0] d, input logic tk,
                       input logic j, input logic [15:0] ja, input logic h);
    mem_ready = rd; mem_data = d; ir_take = tk; jmp_en = j; jmp_addr = ja; halt = h;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_req = 1'b0; m_valid = 1'b0; m_ir = 8'h00; m_pc = 16'h0000;
  endtask

  task automatic model_step();
    if (jmp_en) begin
      m_pc = jmp_addr; m_valid = 1'b0; m_req = !halt;
    end else if (m_req) begin
      if (mem_ready) begin
        m_ir = mem_data; m_pc = 16'((32'(m_pc) + 1) % 65536);
        m_valid = 1'b1; m_req = 1'b0;
      end
    end else if (m_valid) begin
      if (ir_take) begin
        m_valid = 1'b0; m_req = !halt;
      end
    end else if (!halt) begin
      m_req = 1'b1;
    end
  endtask

  task automatic chk_all(input string tag, input logic e_req, input logic e_valid,
                         input logic [7:0] e_ir, input logic [15:0] e_pc);
    chk({tag, ".mem_req"},  32'(mem_req),  32'(e_req));
    chk({tag, ".ir_valid"}, 32'(ir_valid), 32'(e_valid));
    chk({tag, ".ir_byte"},  32'(ir_byte),  32'(e_ir));
    chk({tag, ".pc"},       32'(pc),       32'(e_pc));
    chk({tag, ".mem_addr"}, 32'(mem_addr), 32'(e_pc));
  endtask

  initial begin
    vecs[0]  = '{1'b0, 8'h00, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 8'h00, 16'h0000};
    vecs[1]  = '{1'b1, 8'h11, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 8'h11, 16'h0001};
    vecs[2]  = '{1'b0, 8'h00, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 8'h11, 16'h0001};
    vecs[3]  = '{1'b1, 8'h22, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 8'h22, 16'h0002};
    vecs[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 8'h22, 16'h0002};
    vecs[5]  = '{1'b1, 8'h33, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 8'h33, 16'h0003};
    vecs[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 8'h33, 16'h0003};
    vecs[7]  = '{1'b0, 8'h00, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 8'h33, 16'h0003};
    vecs[8]  = '{1'b0, 8'h00, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 8'h33, 16'h0003};
    vecs[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 8'h33, 16'h0003};
    vecs[10] = '{1'b1, 8'h44, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 8'h44, 16'h0004};
    vecs[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 8'h44, 16'h0004};
    vecs[12] = '{1'b1, 8'hAA, 1'b0, 1'b1, 16'h1234, 1'b0, 1'b1, 1'b0, 8'h44, 16'h1234};
    vecs[13] = '{1'b0, 8'h00, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 8'h44, 16'h1234};
    vecs[14] = '{1'b1, 8'h55, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 8'h55, 16'h1235};
    vecs[15] = '{1'b0, 8'h00, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 8'h55, 16'h1235};
    vecs[16] = '{1'b1, 8'h99, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 8'h55, 16'h1235};
    vecs[17] = '{1'b0, 8'h00, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 8'h55, 16'h1235};
    vecs[18] = '{1'b0, 8'h00, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 8'h55, 16'h1235};
    vecs[19] = '{1'b0, 8'h00, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b1, 1'b0, 8'h55, 16'hFFFF};
    vecs[20] = '{1'b1, 8'h66, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 8'h66, 16'h0000};
    vecs[21] = '{1'b0, 8'h00, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 8'h66, 16'h0000};

    rst = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 1'b0, 16'h0000, 1'b0);
    #2 rst = 1'b1;
    #1 chk_all("reset", 1'b0, 1'b0, 8'h00, 16'h0000);
    cycle();
    chk_all("reset_held", 1'b0, 1'b0, 8'h00, 16'h0000);
    rst = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].ready, vecs[i].data, vecs[i].take, vecs[i].jmp, vecs[i].addr, vecs[i].hlt);
      cycle();
      chk_all($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_valid, vecs[i].e_ir, vecs[i].e_pc);
    end

    // Async reset between edges while a fetch is outstanding.
    drive(1'b0, 8'h00, 1'b0, 1'b1, 16'h0100, 1'b0);
    cycle();
    chk_all("pre_async", 1'b1, 1'b0, 8'h66, 16'h0100);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 16'h0000, 1'b0);
    #2 rst = 1'b1;
    #1 chk_all("async_rst", 1'b0, 1'b0, 8'h00, 16'h0000);
    #1 rst = 1'b0;
    drive(1'b1, 8'h77, 1'b0, 1'b0, 16'h0000, 1'b0);
    cycle();
    chk_all("stale_ready", 1'b1, 1'b0, 8'h00, 16'h0000);

    // Randomized run against the reference model.
    drive(1'b0, 8'h00, 1'b0, 1'b0, 16'h0000, 1'b0);
    #2 rst = 1'b1;
    model_reset();
    #1 rst = 1'b0;
    for (int n = 0; n < 400; n++) begin
      logic [15:0] ja;
      ja = ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom);
      drive(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 15) == 0), ja, ($urandom_range(0, 7) == 0));
      @(posedge clk);
      model_step();
      #1;
      chk_all($sformatf("rand%0d", n), m_req, m_valid, m_ir, m_pc);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
